// File: rtl/adc_sequencer.sv
// Round-robin command scheduler for the MAX10 on-chip ADC: walks a channel mask,
// issues one Avalon-ST command at a time and forwards each matched result as a stb/ack word.
module adc_sequencer #(
  parameter int NUM_SLOTS = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [NUM_SLOTS-1:0] channel_mask,
  output logic                 command_valid,
  output logic [4:0]           command_channel,
  output logic                 command_startofpacket,
  output logic                 command_endofpacket,
  input  logic                 command_ready,
  input  logic                 response_valid,
  input  logic [4:0]           response_channel,
  input  logic [11:0]          response_data,
  output logic [31:0]          sample_out,
  output logic                 sample_stb,
  input  logic                 sample_ack,
  output logic                 overrun,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    ISSUE,
    WAIT_RESP
  } state_t;

  state_t              state;
  logic [SLOT_W-1:0]   last_served;
  logic [SLOT_W-1:0]   next_slot;
  logic [SLOT_W-1:0]   probe;
  logic                found;
  logic [CNT_W-1:0]    timer;
  logic                resp_match;
  logic                timed_out;
  logic                done;
  logic                run;

  assign command_startofpacket = command_valid;
  assign command_endofpacket   = command_valid;

  assign run        = enable && (|channel_mask);
  assign resp_match = (state == WAIT_RESP) && response_valid &&
                      (response_channel == command_channel);
  assign timed_out  = (state == WAIT_RESP) && !resp_match &&
                      (timer == CNT_W'(TIMEOUT - 1));
  assign done       = resp_match || timed_out;

  // Search starts one past the last-served slot so every enabled slot gets a turn.
  always_comb begin
    // NOTE: every variable gets a default up front so no path leaves it unassigned (no latch).
    next_slot = last_served;
    found     = 1'b0;
    probe     = '0;
    for (int i = 1; i <= NUM_SLOTS; i++) begin
      probe = SLOT_W'((int'(last_served) + i) % NUM_SLOTS);
      if (!found && channel_mask[probe]) begin
        next_slot = probe;
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    if (!rst_n) begin
      state           <= IDLE;
      command_valid   <= 1'b0;
      command_channel <= '0;
      last_served     <= SLOT_W'(NUM_SLOTS - 1);
      timer           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run) state <= SELECT;
        end
        SELECT: begin
          if (|channel_mask) begin
            command_channel <= 5'(next_slot);
            command_valid   <= 1'b1;
            state           <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        // Command stays frozen until accepted, whatever enable or the mask do meanwhile.
        ISSUE: begin
          if (command_ready) begin
            command_valid <= 1'b0;
            last_served   <= command_channel[SLOT_W-1:0];
            timer         <= '0;
            state         <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          timer <= timer + CNT_W'(1);
          if (done) state <= run ? SELECT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-entry output register; a new result always overwrites, flagging overrun if unacked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out  <= '0;
      sample_stb  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (resp_match) begin
        sample_out <= {11'd0, response_channel, 4'd0, response_data};
        sample_stb <= 1'b1;
      end else if (sample_ack) begin
        sample_stb <= 1'b0;
      end
      overrun     <= (overrun && !err_clr) || (resp_match && sample_stb && !sample_ack);
      timeout_err <= (timeout_err && !err_clr) || timed_out;
    end
  end

endmodule

// File: tb/tb_adc_sequencer.sv
// Directed bench for adc_sequencer: round robin, command stall, overrun, timeout,
// mask handling and asynchronous reset, with hand-computed expectations.
module tb_adc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  channel_mask = '0;
  logic        command_valid;
  logic [4:0]  command_channel;
  logic        command_startofpacket;
  logic        command_endofpacket;
  logic        command_ready = 1'b0;
  logic        response_valid = 1'b0;
  logic [4:0]  response_channel = '0;
  logic [11:0] response_data = '0;
  logic [31:0] sample_out;
  logic        sample_stb;
  logic        sample_ack = 1'b0;
  logic        overrun;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adc_sequencer #(.NUM_SLOTS(8), .TIMEOUT(16)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .enable                (enable),
    .channel_mask          (channel_mask),
    .command_valid         (command_valid),
    .command_channel       (command_channel),
    .command_startofpacket (command_startofpacket),
    .command_endofpacket   (command_endofpacket),
    .command_ready         (command_ready),
    .response_valid        (response_valid),
    .response_channel      (response_channel),
    .response_data         (response_data),
    .sample_out            (sample_out),
    .sample_stb            (sample_stb),
    .sample_ack            (sample_ack),
    .overrun               (overrun),
    .timeout_err           (timeout_err),
    .err_clr               (err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    enable           = 1'b0;
    channel_mask     = '0;
    command_ready    = 1'b0;
    response_valid   = 1'b0;
    response_channel = '0;
    response_data    = '0;
    sample_ack       = 1'b0;
    err_clr          = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_cmd(input string tag);
    int n = 0;
    while (command_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (command_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_wait: command_valid=%b after %0d cycles, required 1", tag, command_valid, n);
    end
  endtask

  task automatic respond(input logic [4:0] ch, input logic [11:0] data, input logic ack);
    response_valid   = 1'b1;
    response_channel = ch;
    response_data    = data;
    sample_ack       = ack;
    tick();
    response_valid   = 1'b0;
    sample_ack       = 1'b0;
  endtask

  // Waits for a command, checks its channel, accepts it and returns a result 4 cycles later.
  task automatic run_txn(input string tag, input logic [4:0] ch, input logic [11:0] data,
                         input logic ack_with_load);
    wait_cmd(tag);
    checks++;
    if (command_channel !== ch) begin
      failures++;
      $display("FAIL %s_channel: got %0d required %0d", tag, command_channel, ch);
    end
    tick();
    repeat (3) tick();
    respond(ch, data, ack_with_load);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({command_valid, command_startofpacket, command_endofpacket, command_channel,
         sample_out, sample_stb, overrun, timeout_err} !== 43'd0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b ch=%0d out=%h stb=%b ovr=%b to=%b, required all 0",
               command_valid, command_channel, sample_out, sample_stb, overrun, timeout_err);
    end
    do_reset();
    enable = 1'b1;
    repeat (5) tick();
    checks++;
    if (command_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_no_mask: command_valid=%b required 0", command_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [4:0]  exp_ch;
    logic [11:0] data;
    logic [31:0] exp_out;
    do_reset();
    channel_mask  = 8'b0000_0101;
    command_ready = 1'b1;
    enable        = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_ch  = (k % 2 == 0) ? 5'd0 : 5'd2;
      data    = (k % 2 == 0) ? 12'hABC : 12'h123;
      exp_out = (k % 2 == 0) ? 32'h0000_0ABC : 32'h0002_0123;
      wait_cmd("rr");
      checks++;
      if ({command_startofpacket, command_endofpacket} !== 2'b11) begin
        failures++;
        $display("FAIL rr_sop_eop: got %b required 11", {command_startofpacket, command_endofpacket});
      end
      run_txn("rr", exp_ch, data, 1'b0);
      checks++;
      if (sample_stb !== 1'b1 || sample_out !== exp_out) begin
        failures++;
        $display("FAIL rr_sample%0d: stb=%b out=%h required stb=1 out=%h", k, sample_stb, sample_out, exp_out);
      end
      checks++;
      if (command_valid !== 1'b0) begin
        failures++;
        $display("FAIL rr_select_gap%0d: command_valid=%b required 0", k, command_valid);
      end
      sample_ack = 1'b1;
      tick();
      sample_ack = 1'b0;
      checks++;
      if (sample_stb !== 1'b0 || command_valid !== 1'b1) begin
        failures++;
        $display("FAIL rr_ack_next%0d: stb=%b valid=%b required stb=0 valid=1", k, sample_stb, command_valid);
      end
    end
  endtask

  task automatic test_stall();
    logic bad = 1'b0;
    do_reset();
    channel_mask  = 8'b0010_0000;
    command_ready = 1'b0;
    enable        = 1'b1;
    wait_cmd("stall");
    for (int i = 0; i < 10; i++) begin
      if (i == 3) enable = 1'b0;
      checks++;
      if (command_valid !== 1'b1 || command_channel !== 5'd5) begin
        failures++;
        $display("FAIL stall_hold%0d: valid=%b ch=%0d required valid=1 ch=5", i, command_valid, command_channel);
      end
      tick();
    end
    command_ready = 1'b1;
    tick();
    command_ready = 1'b0;
    checks++;
    if (command_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_handshake: command_valid=%b required 0", command_valid);
    end
    repeat (3) tick();
    respond(5'd5, 12'h5A5, 1'b0);
    checks++;
    if (sample_stb !== 1'b1 || sample_out !== 32'h0005_05A5) begin
      failures++;
      $display("FAIL stall_sample: stb=%b out=%h required stb=1 out=000505a5", sample_stb, sample_out);
    end
    command_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (command_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL stall_idle_after: command issued after enable dropped");
    end
  endtask

  task automatic test_overrun();
    do_reset();
    channel_mask  = 8'b0000_0001;
    command_ready = 1'b1;
    enable        = 1'b1;
    run_txn("ovr", 5'd0, 12'h111, 1'b0);
    checks++;
    if (overrun !== 1'b0 || sample_stb !== 1'b1) begin
      failures++;
      $display("FAIL ovr_first: overrun=%b stb=%b required 0 and 1", overrun, sample_stb);
    end
    enable = 1'b0;
    run_txn("ovr", 5'd0, 12'h222, 1'b0);
    checks++;
    if (overrun !== 1'b1 || sample_out !== 32'h0000_0222 || sample_stb !== 1'b1) begin
      failures++;
      $display("FAIL ovr_second: overrun=%b out=%h stb=%b required 1 00000222 1", overrun, sample_out, sample_stb);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0 || sample_stb !== 1'b1) begin
      failures++;
      $display("FAIL ovr_clear: overrun=%b stb=%b required 0 and 1", overrun, sample_stb);
    end

    do_reset();
    channel_mask  = 8'b0000_0001;
    command_ready = 1'b1;
    enable        = 1'b1;
    run_txn("ack", 5'd0, 12'h333, 1'b0);
    enable = 1'b0;
    run_txn("ack", 5'd0, 12'h444, 1'b1);
    checks++;
    if (overrun !== 1'b0 || sample_stb !== 1'b1 || sample_out !== 32'h0000_0444) begin
      failures++;
      $display("FAIL ack_with_load: overrun=%b stb=%b out=%h required 0 1 00000444", overrun, sample_stb, sample_out);
    end
    sample_ack = 1'b1;
    tick();
    checks++;
    if (sample_stb !== 1'b0) begin
      failures++;
      $display("FAIL ack_clear: stb=%b required 0", sample_stb);
    end
    tick();
    sample_ack = 1'b0;
    checks++;
    if (sample_stb !== 1'b0 || sample_out !== 32'h0000_0444) begin
      failures++;
      $display("FAIL ack_idle_ignored: stb=%b out=%h required 0 00000444", sample_stb, sample_out);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    channel_mask  = 8'b0000_0110;
    command_ready = 1'b1;
    enable        = 1'b1;
    wait_cmd("to");
    checks++;
    if (command_channel !== 5'd1) begin
      failures++;
      $display("FAIL to_first_channel: got %0d required 1", command_channel);
    end
    tick();
    for (int e = 1; e <= 15; e++) begin
      if (e == 3) begin
        response_valid   = 1'b1;
        response_channel = 5'd7;
        response_data    = 12'h777;
      end
      tick();
      response_valid = 1'b0;
    end
    checks++;
    if (timeout_err !== 1'b0 || sample_stb !== 1'b0) begin
      failures++;
      $display("FAIL to_early: timeout_err=%b stb=%b required 0 0 after 15 cycles", timeout_err, sample_stb);
    end
    tick();
    checks++;
    if (timeout_err !== 1'b1 || sample_stb !== 1'b0) begin
      failures++;
      $display("FAIL to_fire: timeout_err=%b stb=%b required 1 0 after 16 cycles", timeout_err, sample_stb);
    end
    wait_cmd("to_next");
    checks++;
    if (command_channel !== 5'd2) begin
      failures++;
      $display("FAIL to_next_channel: got %0d required 2", command_channel);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL to_clear: timeout_err=%b required 0", timeout_err);
    end
  endtask

  task automatic test_mask();
    logic bad = 1'b0;
    do_reset();
    command_ready = 1'b1;
    enable        = 1'b1;
    channel_mask  = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (command_valid !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL mask_zero: command issued with empty mask");
    end
    channel_mask = 8'h01;
    wait_cmd("mask");
    checks++;
    if (command_channel !== 5'd0) begin
      failures++;
      $display("FAIL mask_first: got %0d required 0", command_channel);
    end
    tick();
    channel_mask = 8'h80;
    repeat (2) tick();
    respond(5'd0, 12'h0AA, 1'b0);
    wait_cmd("mask_change");
    checks++;
    if (command_channel !== 5'd7) begin
      failures++;
      $display("FAIL mask_change: got %0d required 7", command_channel);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    channel_mask  = 8'b0000_1001;
    command_ready = 1'b1;
    enable        = 1'b1;
    run_txn("rst", 5'd0, 12'hABC, 1'b0);
    wait_cmd("rst");
    checks++;
    if (command_channel !== 5'd3 || sample_stb !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: ch=%0d stb=%b required 3 and 1", command_channel, sample_stb);
    end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({command_valid, command_startofpacket, command_endofpacket, command_channel,
         sample_out, sample_stb, overrun, timeout_err} !== 43'd0) begin
      failures++;
      $display("FAIL rst_async: valid=%b ch=%0d out=%h stb=%b required all 0",
               command_valid, command_channel, sample_out, sample_stb);
    end
    tick();
    rst_n            = 1'b1;
    response_valid   = 1'b1;
    response_channel = 5'd3;
    response_data    = 12'h333;
    tick();
    response_valid = 1'b0;
    checks++;
    if (sample_stb !== 1'b0) begin
      failures++;
      $display("FAIL rst_late_resp: stb=%b required 0", sample_stb);
    end
    wait_cmd("rst_after");
    checks++;
    if (command_channel !== 5'd0) begin
      failures++;
      $display("FAIL rst_first_cmd: got %0d required 0", command_channel);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_round_robin();
    test_stall();
    test_overrun();
    test_timeout();
    test_mask();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
